// File: rtl/counter_updown_param.sv
`default_nettype none
// ============================================================================
// Module      : counter_updown_param
// Description : Parametrised up/down counter with programmable upper limit,
//               parallel load, wrap/saturate/bounce limit modes, a
//               terminal-count pulse and sticky overflow/underflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_updown_param #(
    parameter int WIDTH     = 8,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] count,
    output logic             dir_out,
    output logic             tc,
    output logic             ovf,
    output logic             unf
);

    // Modes 00 and 11 both fall through to wrap behaviour.
    localparam logic [1:0]       c_MODE_SAT    = 2'b01;
    localparam logic [1:0]       c_MODE_BOUNCE = 2'b10;
    localparam logic [WIDTH-1:0] c_RESET_COUNT = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] c_ONE         = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             bdir_q,  bdir_d;
    logic             tc_q,    tc_d;
    logic             ovf_q,   ovf_d;
    logic             unf_q,   unf_d;

    logic w_bounce;
    logic w_sat;
    logic w_up;
    logic w_set_ovf;
    logic w_set_unf;

    assign w_bounce = (mode == c_MODE_BOUNCE);
    assign w_sat    = (mode == c_MODE_SAT);
    assign w_up     = w_bounce ? bdir_q : dir;

    always_comb begin
        count_d   = count_q;
        tc_d      = 1'b0;
        bdir_d    = w_bounce ? bdir_q : dir;
        w_set_ovf = 1'b0;
        w_set_unf = 1'b0;

        if (load) begin
            count_d = (load_val > max_val) ? max_val : load_val;
            bdir_d  = dir;
        end else if (en) begin
            // Every branch below is a limit event unless it is a plain step.
            tc_d = 1'b1;
            if (count_q > max_val) begin
                count_d   = max_val;
                w_set_ovf = !w_bounce;
            end else if (w_bounce && (max_val == '0)) begin
                count_d = '0;
                bdir_d  = ~bdir_q;
            end else if (w_up) begin
                if (count_q != max_val) begin
                    count_d = count_q + c_ONE;
                    tc_d    = 1'b0;
                end else if (w_bounce) begin
                    count_d = max_val - c_ONE;
                    bdir_d  = 1'b0;
                end else if (w_sat) begin
                    w_set_ovf = 1'b1;
                end else begin
                    count_d   = '0;
                    w_set_ovf = 1'b1;
                end
            end else begin
                if (count_q != '0) begin
                    count_d = count_q - c_ONE;
                    tc_d    = 1'b0;
                end else if (w_bounce) begin
                    count_d = c_ONE;
                    bdir_d  = 1'b1;
                end else if (w_sat) begin
                    w_set_unf = 1'b1;
                end else begin
                    count_d   = max_val;
                    w_set_unf = 1'b1;
                end
            end
        end

        // A set event in the same cycle as clr_flags leaves the flag high.
        ovf_d = w_set_ovf | (ovf_q & ~clr_flags);
        unf_d = w_set_unf | (unf_q & ~clr_flags);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= c_RESET_COUNT;
            bdir_q  <= 1'b1;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            bdir_q  <= bdir_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign count   = count_q;
    assign dir_out = w_up;
    assign tc      = tc_q;
    assign ovf     = ovf_q;
    assign unf     = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_updown_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_updown_param
// Description : Self-checking bench for counter_updown_param (WIDTH=8,
//               RESET_VAL=5) using a vector table and an expectation queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_updown_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       dir;
    logic [1:0] mode;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] max_val;
    logic       clr_flags;
    logic [7:0] count;
    logic       dir_out;
    logic       tc;
    logic       ovf;
    logic       unf;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       ld;
        logic       en;
        logic       dir;
        logic [1:0] mode;
        logic [7:0] lv;
        logic [7:0] mx;
        logic       clr;
        logic [7:0] e_count;
        logic       e_dir;
        logic       e_tc;
        logic       e_ovf;
        logic       e_unf;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    counter_updown_param #(
        .WIDTH     (8),
        .RESET_VAL (5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .dir       (dir),
        .mode      (mode),
        .load      (load),
        .load_val  (load_val),
        .max_val   (max_val),
        .clr_flags (clr_flags),
        .count     (count),
        .dir_out   (dir_out),
        .tc        (tc),
        .ovf       (ovf),
        .unf       (unf)
    );

    always #5 clk = ~clk;

    function automatic vec_t V(input logic ld_i, input logic en_i, input logic dir_i,
                               input logic [1:0] mode_i, input logic [7:0] lv_i,
                               input logic [7:0] mx_i, input logic clr_i,
                               input logic [7:0] c_i, input logic d_i, input logic t_i,
                               input logic o_i, input logic u_i);
        vec_t v;
        v.ld = ld_i; v.en = en_i; v.dir = dir_i; v.mode = mode_i;
        v.lv = lv_i; v.mx = mx_i; v.clr = clr_i;
        v.e_count = c_i; v.e_dir = d_i; v.e_tc = t_i; v.e_ovf = o_i; v.e_unf = u_i;
        return v;
    endfunction

    task automatic check(input string nm, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step=%0d actual=%0h expected=%0h", nm, idx, act, exp);
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, compare after the edge.
    task automatic step(input vec_t v, input int idx);
        vec_t e;
        load = v.ld; en = v.en; dir = v.dir; mode = v.mode;
        load_val = v.lv; max_val = v.mx; clr_flags = v.clr;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("count",   idx, 32'(count),   32'(e.e_count));
        check("dir_out", idx, 32'(dir_out), 32'(e.e_dir));
        check("tc",      idx, 32'(tc),      32'(e.e_tc));
        check("ovf",     idx, 32'(ovf),     32'(e.e_ovf));
        check("unf",     idx, 32'(unf),     32'(e.e_unf));
    endtask

    initial begin
        // Saturate down from 2
        tbl.push_back(V(1,0,0,2'd1,  2,255,0,   2,0,0,0,0));
        tbl.push_back(V(0,1,0,2'd1,  0,255,0,   1,0,0,0,0));
        tbl.push_back(V(0,1,0,2'd1,  0,255,0,   0,0,0,0,0));
        tbl.push_back(V(0,1,0,2'd1,  0,255,0,   0,0,1,0,1));
        tbl.push_back(V(0,1,0,2'd1,  0,255,0,   0,0,1,0,1));
        tbl.push_back(V(0,0,0,2'd1,  0,255,1,   0,0,0,0,0));
        // Bounce 0..3 with dir input held low (ignored)
        tbl.push_back(V(1,0,1,2'd2,  0,  3,0,   0,1,0,0,0));
        tbl.push_back(V(0,1,0,2'd2,  0,  3,0,   1,1,0,0,0));
        tbl.push_back(V(0,1,0,2'd2,  0,  3,0,   2,1,0,0,0));
        tbl.push_back(V(0,1,0,2'd2,  0,  3,0,   3,1,0,0,0));
        tbl.push_back(V(0,1,0,2'd2,  0,  3,0,   2,0,1,0,0));
        tbl.push_back(V(0,1,0,2'd2,  0,  3,0,   1,0,0,0,0));
        tbl.push_back(V(0,1,0,2'd2,  0,  3,0,   0,0,0,0,0));
        tbl.push_back(V(0,1,0,2'd2,  0,  3,0,   1,1,1,0,0));
        tbl.push_back(V(0,1,0,2'd2,  0,  3,0,   2,1,0,0,0));
        // Bounce with max_val = 0: out-of-range clamp, then bdir toggles
        tbl.push_back(V(0,1,0,2'd2,  0,  0,0,   0,1,1,0,0));
        tbl.push_back(V(0,1,0,2'd2,  0,  0,0,   0,0,1,0,0));
        tbl.push_back(V(0,1,0,2'd2,  0,  0,0,   0,1,1,0,0));
        // Wrap / mode 11 with max_val = 0
        tbl.push_back(V(0,1,1,2'd0,  0,  0,0,   0,1,1,1,0));
        tbl.push_back(V(0,1,0,2'd3,  0,  0,0,   0,0,1,1,1));
        tbl.push_back(V(0,0,0,2'd0,  0,  0,1,   0,0,0,0,0));
        // Load clamp, priority over en, then max_val lowered at run time
        tbl.push_back(V(1,1,1,2'd0,200,100,0, 100,1,0,0,0));
        tbl.push_back(V(0,1,0,2'd0,  0, 50,0,  50,0,1,1,0));
        tbl.push_back(V(0,1,0,2'd0,  0, 50,0,  49,0,0,1,0));
        tbl.push_back(V(0,0,0,2'd0,  0, 50,1,  49,0,0,0,0));
        // Entering bounce keeps the last (down) direction
        tbl.push_back(V(0,1,1,2'd2,  0, 50,0,  48,0,0,0,0));
        // Reach 37 with ovf set, ahead of the async reset
        tbl.push_back(V(1,0,1,2'd0,200,255,0, 200,1,0,0,0));
        tbl.push_back(V(0,1,1,2'd0,  0, 37,0,  37,1,1,1,0));

        reset = 1'b1; en = 1'b0; dir = 1'b1; mode = 2'd0; load = 1'b0;
        load_val = 8'd0; max_val = 8'd255; clr_flags = 1'b0;
        #12;
        check("rst_count", 0, 32'(count), 32'd5);
        check("rst_tc",    0, 32'(tc),    32'd0);
        check("rst_ovf",   0, 32'(ovf),   32'd0);
        check("rst_unf",   0, 32'(unf),   32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Full-range wrap up from 0
        step(V(1,0,1,2'd0,0,255,0, 0,1,0,0,0), 1000);
        for (int i = 0; i < 256; i++)
            step(V(0,1,1,2'd0,0,255,0, 8'(i+1),1,(i==255),(i==255),0), 1001 + i);
        step(V(0,1,1,2'd0,0,255,0,   1,1,0,1,0), 1300);
        step(V(0,0,1,2'd0,0,255,1,   1,1,0,0,0), 1301);
        // Set-wins race between wrap and clr_flags
        step(V(1,0,1,2'd0,255,255,0, 255,1,0,0,0), 1302);
        step(V(0,1,1,2'd0,0,255,1,   0,1,1,1,0), 1303);
        step(V(0,0,1,2'd0,0,255,1,   0,1,0,0,0), 1304);

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i], i);

        // Asynchronous reset between edges
        @(negedge clk);
        en = 1'b0; load = 1'b0; clr_flags = 1'b0;
        reset = 1'b1;
        #1;
        check("arst_count", 2000, 32'(count), 32'd5);
        check("arst_tc",    2000, 32'(tc),    32'd0);
        check("arst_ovf",   2000, 32'(ovf),   32'd0);
        check("arst_unf",   2000, 32'(unf),   32'd0);
        #1;
        reset = 1'b0;
        step(V(0,1,1,2'd0,0,255,0, 6,1,0,0,0), 2001);
        step(V(0,1,1,2'd0,0,255,0, 7,1,0,0,0), 2002);
        step(V(0,1,1,2'd0,0,255,0, 8,1,0,0,0), 2003);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
